// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter between the L1 I-refill and D-refill/writeback paths for
// one shared burst memory port: grant, address phase, then pass-through beats.
module l1_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  d_wready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE, ADDR, RBURST, WBURST} state_e;

  localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] R_LAST = CW'(READ_BURST_LEN - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WRITE_BURST_LEN - 1);

  // owner/last_owner encoding: 0 = I side, 1 = D side
  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  i_gnt_q, i_gnt_d;
  logic                  d_gnt_q, d_gnt_d;
  logic                  win_d;
  logic                  rd_beat, wr_beat;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    i_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    win_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // A tie goes to whichever side was not served last
          win_d   = (i_req && d_req) ? ~last_owner_q : d_req;
          owner_d = win_d;
          addr_d  = win_d ? d_addr : i_addr;
          we_d    = win_d & d_we;
          i_gnt_d = ~win_d;
          d_gnt_d = win_d;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (mem_ack) begin
          cnt_d        = '0;
          last_owner_d = owner_q;
          state_d      = we_q ? WBURST : RBURST;
        end
      end
      RBURST: begin
        if (mem_rvalid) begin
          if (cnt_q == R_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WBURST: begin
        if (mem_wready) begin
          if (cnt_q == W_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      i_gnt_q      <= i_gnt_d;
      d_gnt_q      <= d_gnt_d;
    end
  end

  // Data beats are pure pass-through, gated by state so idle strays never leak
  always_comb begin
    rd_beat   = (state_q == RBURST) && mem_rvalid;
    wr_beat   = (state_q == WBURST) && mem_wready;
    i_gnt     = i_gnt_q;
    d_gnt     = d_gnt_q;
    mem_req   = (state_q == ADDR);
    mem_we    = we_q;
    mem_addr  = addr_q;
    i_rvalid  = rd_beat && !owner_q;
    d_rvalid  = rd_beat && owner_q;
    i_rdata   = ((state_q == RBURST) && !owner_q) ? mem_rdata : '0;
    d_rdata   = ((state_q == RBURST) && owner_q) ? mem_rdata : '0;
    i_done    = i_rvalid && (cnt_q == R_LAST);
    d_done    = (d_rvalid && (cnt_q == R_LAST)) || (wr_beat && (cnt_q == W_LAST));
    d_wready  = wr_beat;
    mem_wdata = (state_q == WBURST) ? d_wdata : '0;
    dbg_state = state_q;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Arbitrates the shared memory-side burst port between the L1 instruction-cache refill path and the L1 data-cache refill/writeback path. Grants one whole burst at a time with round-robin fairness, then sequences the address phase and the read or write data beats. Sits between `L1_cache` and the system memory, clocked in the `sys_clk` domain.

## Interface
- `ADDR_WIDTH`, 32: address width on all ports.
- `DATA_WIDTH`, 32: beat width.
- `READ_BURST_LEN`, 8: beats per read burst, ≥1.
- `WRITE_BURST_LEN`, 8: beats per write burst, ≥1.

- `sys_clk`  in  1  the single clock; all logic is on its rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  I-side refill request. Held with `i_addr` until `i_gnt`.
- `i_addr`  in  ADDR_WIDTH  I-side burst start address.
- `i_gnt`  out  1  one-cycle pulse: I request accepted.
- `i_rvalid`  out  1  I read beat valid.
- `i_rdata`  out  DATA_WIDTH  I read beat data.
- `i_done`  out  1  pulse with the last I beat.
- `d_req`  in  1  D-side request. Held with `d_we`/`d_addr` until `d_gnt`.
- `d_we`  in  1  1 = writeback burst, 0 = refill burst.
- `d_addr`  in  ADDR_WIDTH  D-side burst start address.
- `d_wdata`  in  DATA_WIDTH  current write beat; advances on `d_wready`.
- `d_gnt`, `d_rvalid`, `d_done`  out  1  D equivalents of the I signals.
- `d_rdata`  out  DATA_WIDTH  D read beat data.
- `d_wready`  out  1  current `d_wdata` beat consumed this cycle.
- `mem_req`  out  1  address-phase request.
- `mem_we`  out  1  burst direction.
- `mem_addr`  out  ADDR_WIDTH  burst start address.
- `mem_ack`  in  1  address phase accepted.
- `mem_wdata`  out  DATA_WIDTH  write beat.
- `mem_wready`  in  1  memory takes `mem_wdata` this cycle.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rdata`  in  DATA_WIDTH  read beat data.

## Operation
- FSM states: IDLE, ADDR, RBURST, WBURST.
- **IDLE**
  - If exactly one of `i_req`/`d_req` is high, that side wins.
  - If both are high, the side not served last wins.
  - `last_owner` resets to D, so I wins the first tie.
  - On a win: register `owner`, address and direction (I side always reads; D side uses `d_we`), then go to ADDR.
- **ADDR**
  - `mem_req`=1; `mem_addr` and `mem_we` come from registers.
  - The owner's `gnt` is a registered pulse in the first ADDR cycle only.
  - Requesters may drop `req` after `gnt`.
  - Stay in ADDR until `mem_ack`.
  - On `mem_ack`, clear the beat counter and go to RBURST (`mem_we`=0) or WBURST (`mem_we`=1). Update `last_owner`.
- **RBURST**
  - Combinational passthrough: owner's `rvalid` = `mem_rvalid`, `rdata` = `mem_rdata`.
  - Non-owner `rvalid` is 0.
  - Count beats on `mem_rvalid`. The beat with count = `READ_BURST_LEN`-1 asserts the owner's `done` combinationally, and the FSM returns to IDLE.
- **WBURST** (D owner only)
  - `mem_wdata` = `d_wdata`; `d_wready` = `mem_wready`.
  - Count beats on `mem_wready`. The last beat (`WRITE_BURST_LEN`-1) asserts `d_done` and returns to IDLE.
- **Beat counter**: width `$clog2(max(READ_BURST_LEN, WRITE_BURST_LEN)+1)`, no wrap. For a length of 1, the first beat is also the last.
- **Ignored inputs**: `mem_ack` outside ADDR, `mem_rvalid` outside RBURST, and `mem_wready` outside WBURST are ignored.
- **Requests during a burst**: a request arriving during a burst waits. It is evaluated in IDLE.

## Timing
- **Reset values**: every output is 0 (`mem_addr`, `mem_wdata` and `rdata` outputs included). State = IDLE, counter = 0, `last_owner` = D.
- **Grant latency**: `req` high in IDLE at cycle N → `gnt` and `mem_req` high at cycle N+1.
- **Address phase**: `mem_req` stays high until the cycle `mem_ack` is sampled (inclusive). It is low from the next cycle.
- **Data beats**: zero latency, combinational pass-through in both directions.
- **Idle gap**: the last-beat cycle → IDLE next cycle → next ADDR earliest one cycle later. At least one IDLE cycle always separates bursts.
- **Reset mid-burst**: reset in any state returns to IDLE next cycle with all outputs 0. No `done` is issued and the partial burst is abandoned. The memory side shares `sys_rst`.
- **Tie history**: a simultaneous `i_req`/`d_req` in consecutive arbitrations alternates winners. Non-tied arbitration still updates `last_owner`.

## Test plan
- **I refill**: `i_req`, `i_addr`=0x100, `mem_ack` 2 cycles after `mem_req`, 8 `mem_rvalid` beats with data 0..7 → `i_gnt` at N+1; `i_rdata` = 0..7; `i_done` on beat 7; `d_rvalid` never high.
- **D writeback**: `d_we`=1, `d_addr`=0x2000, `mem_wready` toggling → exactly 8 `d_wready` pulses; `mem_wdata` tracks `d_wdata`; `d_done` on the 8th.
- **Tie fairness**: both requesting continuously for 4 bursts → grant order I, D, I, D; IDLE gap ≥1 cycle each time.
- **Request during burst**: `d_req` raised while an I read is mid-burst → D is served only after `i_done` plus one IDLE cycle.
- **Reset mid-burst**: `sys_rst` at read beat 3 → next cycle all outputs 0; a subsequent I request completes normally with 8 beats.
- **Length 1**: `READ_BURST_LEN`=`WRITE_BURST_LEN`=1 → `done` on the first beat for both directions; stray `mem_rvalid` in IDLE causes no output.
